// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Adds two WIDTH-bit operands one bit per clock, LSB first, reusing a single
// full-add stage built from two half adders and an OR gate. The carry between
// bit positions is held in a flop, so the datapath stays one bit wide and the
// cost is latency: WIDTH clocks per addition.
//
// The requester issues a one-cycle (or longer) start while the block is idle.
// The block then reports busy until the result has been presented, and pulses
// done for one cycle when sum/carry_out are final.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      request, only looked at while idle
//   a, b       in   WIDTH  operands, captured on the accepting edge
//   busy       out  1      high while an addition is running or completing
//   done       out  1      one-cycle pulse, sum/carry_out valid
//   sum        out  WIDTH  a + b modulo 2^WIDTH
//   carry_out  out  1      carry out of the top bit
// -----------------------------------------------------------------------------

// One-bit half adder used as the building block of the serial add stage.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);
    // A 1-bit build still needs a 1-bit counter so the compare is well formed.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic             carry_out_r;
    logic             busy_r;
    logic             done_r;

    logic             prop_s;
    logic             gen_s;
    logic             bit_sum_s;
    logic             carry_prop_s;
    logic             bit_carry_s;
    logic [WIDTH-1:0] sum_next_s;

    // Full-add of the current LSBs: first half adder combines the operand
    // bits, second folds in the stored carry; either stage may produce carry.
    half_adder u_ha_ab (
        .x (a_sr_r[0]),
        .y (b_sr_r[0]),
        .s (prop_s),
        .c (gen_s)
    );

    half_adder u_ha_c (
        .x (prop_s),
        .y (carry_r),
        .s (bit_sum_s),
        .c (carry_prop_s)
    );

    assign bit_carry_s = gen_s | carry_prop_s;

    // The new sum bit enters at the MSB so that after WIDTH steps bit 0 of the
    // result has arrived at position 0.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign sum_next_s = bit_sum_s;
        end else begin : g_sum_wn
            assign sum_next_s = {bit_sum_s, sum_r[WIDTH-1:1]};
        end
    endgenerate

    // Sequencer: operand capture, one bit step per RUN cycle, and the
    // registered busy/done decodes of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            a_sr_r      <= '0;
            b_sr_r      <= '0;
            sum_r       <= '0;
            carry_r     <= 1'b0;
            cnt_r       <= '0;
            carry_out_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_sr_r      <= a;
                        b_sr_r      <= b;
                        sum_r       <= '0;
                        carry_r     <= 1'b0;
                        cnt_r       <= '0;
                        carry_out_r <= 1'b0;
                        busy_r      <= 1'b1;
                        state_r     <= ST_RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    sum_r   <= sum_next_s;
                    a_sr_r  <= a_sr_r >> 1'b1;
                    b_sr_r  <= b_sr_r >> 1'b1;
                    carry_r <= bit_carry_s;
                    cnt_r   <= cnt_r + CW'(1);
                    busy_r  <= 1'b1;
                    if (cnt_r == CNT_LAST) begin
                        carry_out_r <= bit_carry_s;
                        done_r      <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        done_r  <= 1'b0;
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    // Result registers are left alone so they hold until the
                    // next request is accepted.
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign sum       = sum_r;
    assign carry_out = carry_out_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;

    logic         start1;
    logic [0:0]   a1;
    logic [0:0]   b1;
    logic         busy1;
    logic         done1;
    logic [0:0]   sum1;
    logic         carry_out1;

    int checks = 0;
    int errors = 0;

    // Expected {carry_out, sum} for every accepted request, oldest first.
    logic [W:0] exp_q[$];
    logic       prev_done = 1'b0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .carry_out(carry_out)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .carry_out(carry_out1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer addition of the operands.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    // Monitor: whenever the DUT presents done, pop and compare.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    chk("result", {23'd0, carry_out, sum}, {23'd0, exp_q.pop_front()});
                end
                if (prev_done) chk("done_width", 32'd2, 32'd1);
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // Issue one request at a negedge while idle; optionally hold start and
    // scramble the operands for the whole operation. Returns at the negedge
    // where the DUT is idle again.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit hold);
        int busy_n = 0;
        int done_k = 0;
        bit fin = 1'b0;
        exp_q.push_back(ref_add(av, bv));
        a = av;
        b = bv;
        start = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (hold) begin
                a = W'($urandom);
                b = W'($urandom);
            end else begin
                start = 1'b0;
            end
            if (busy) busy_n++;
            if (done) done_k = i;
            if (!busy) begin
                fin = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!fin) chk("op_timeout", 32'd1, 32'd0);
        chk("busy_cycles", busy_n, W + 1);
        chk("done_latency", done_k, W + 1);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        start1 = 1'b0;
        a1     = '0;
        b1     = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_sum", {24'd0, sum}, 32'd0);
        chk("reset_cout", {31'd0, carry_out}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(8'h00, 8'h00, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0);
        do_op(8'hA5, 8'h5A, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b0);
        do_op(8'h3C, 8'h81, 1'b1);

        for (int n = 0; n < 30; n++) begin
            do_op(W'($urandom), W'($urandom), bit'($urandom_range(0, 3) == 0));
        end

        // Reset during RUN: outputs clear at once and no result appears.
        a = 8'h77;
        b = 8'h99;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_sum", {24'd0, sum}, 32'd0);
        chk("midrst_cout", {31'd0, carry_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(8'h0F, 8'h01, 1'b0);
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);

        // Single-bit build: every operand combination.
        for (int k = 0; k < 4; k++) begin
            int dk = 0;
            a1 = 1'(k & 1);
            b1 = 1'(k >> 1);
            start1 = 1'b1;
            for (int i = 1; i <= 10; i++) begin
                @(negedge clk);
                start1 = 1'b0;
                if (done1 && dk == 0) begin
                    dk = i;
                    chk("w1_result", {30'd0, carry_out1, sum1},
                        32'(int'(a1) + int'(b1)));
                end
                if (!busy1) break;
            end
            chk("w1_done_latency", dk, 32'd2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
